layer_trigger_engine: RTL

LAYER_TRIGGER_ENGINE -- requirements
Module: layer_trigger_engine

---
 rtl/layer_trigger_engine.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/layer_trigger_engine.sv
// Layer coincidence trigger: per-channel hit stretching, layer/hit counting,
// condition evaluation, IDLE/COLLECT/COMMIT record builder and a FWFT record FIFO.
module layer_trigger_engine #(
  parameter int N_CH       = 64,
  parameter int N_LAYERS   = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int TS_W       = 56
) (
  input  logic              clk_adc,
  input  logic              nrst,
  input  logic [N_CH-1:0]   hit_in,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic [5:0]        trig_enable,
  input  logic [5:0]        prescale_pass,
  input  logic              ext_trig,
  input  logic [5:0]        coincidence_time,
  input  logic [7:0]        dead_time,
  input  logic [4:0]        out_width,
  input  logic [7:0]        n_layer_thr,
  input  logic [7:0]        n_hit_thr,
  input  logic              clear,
  output logic              trig_out,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [5:0]        rec_bits,
  output logic [TS_W-1:0]   rec_ts,
  output logic [15:0]       overflow_cnt,
  output logic [TS_W-1:0]   timestamp
);

  localparam int CPL    = N_CH / N_LAYERS;
  localparam int LCNT_W = $clog2(CPL + 1);
  localparam int TCNT_W = $clog2(N_CH + 1);
  localparam int LAY_W  = $clog2(N_LAYERS + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMMIT} state_t;

  logic [N_CH-1:0]                    r_hit_p0;
  logic [N_CH-1:0][5:0]               r_str_p1;
  logic [N_LAYERS-1:0][LCNT_W-1:0]    r_lcnt_p2;
  logic [TCNT_W-1:0]                  r_tcnt_p2;
  logic [LAY_W-1:0]                   r_nlay_p2;
  logic [5:0]                         r_cond_p3;

  logic [N_CH-1:0]                    w_active;
  logic [N_LAYERS-1:0][LCNT_W-1:0]    w_lcnt;
  logic [TCNT_W-1:0]                  w_tcnt;
  logic [LAY_W-1:0]                   w_nlay;
  logic [N_LAYERS-1:0]                w_lhit;
  logic [5:0]                         w_cond;
  logic [5:0]                         w_accept;

  state_t          r_state;
  logic [7:0]      r_win;
  logic [5:0]      r_bits;
  logic [TS_W-1:0] r_ts_lat;
  logic            r_trig;
  logic [4:0]      r_trig_rem;
  logic [TS_W-1:0] r_ts;
  logic [15:0]     r_ovf;
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic [5:0]      r_mem_bits [FIFO_DEPTH];
  logic [TS_W-1:0] r_mem_ts   [FIFO_DEPTH];

  logic [7:0] w_win_load;
  logic [4:0] w_width_load;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_push;
  logic       w_commit;

  always_comb begin
    w_active = '0;
    for (int c = 0; c < N_CH; c++)
      w_active[c] = (r_str_p1[c] != 6'd0);
  end

  always_comb begin
    w_lcnt = '0;
    w_tcnt = '0;
    w_nlay = '0;
    for (int l = 0; l < N_LAYERS; l++) begin
      for (int i = 0; i < CPL; i++)
        w_lcnt[l] = w_lcnt[l] + LCNT_W'(w_active[l*CPL + i]);
      w_tcnt = w_tcnt + TCNT_W'(w_lcnt[l]);
      if (w_lcnt[l] != '0)
        w_nlay = w_nlay + LAY_W'(1);
    end
  end

  always_comb begin
    w_lhit = '0;
    w_cond = '0;
    for (int l = 0; l < N_LAYERS; l++)
      w_lhit[l] = (r_lcnt_p2[l] != '0);
    w_cond[0] = &w_lhit;
    w_cond[1] = (32'(r_nlay_p2) >= 32'(n_layer_thr));
    for (int l = 0; l < N_LAYERS - 1; l++)
      w_cond[2] = w_cond[2] | (w_lhit[l] & w_lhit[l+1]);
    for (int l = 0; l < N_LAYERS - 2; l++)
      w_cond[3] = w_cond[3] | (w_lhit[l] & w_lhit[l+2]);
    w_cond[4] = (32'(r_tcnt_p2) >= 32'(n_hit_thr));
    w_cond[5] = ext_trig;
  end

  assign w_accept     = r_cond_p3 & trig_enable & prescale_pass;
  assign w_win_load   = (dead_time == 8'd0) ? 8'd1 : dead_time;
  assign w_width_load = (out_width == 5'd0) ? 5'd1 : out_width;

  // p0 masked hits -> p1 stretch counters -> p2 counts -> p3 conditions
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      r_hit_p0  <= '0;
      r_str_p1  <= '0;
      r_lcnt_p2 <= '0;
      r_tcnt_p2 <= '0;
      r_nlay_p2 <= '0;
      r_cond_p3 <= '0;
    end else if (clear) begin
      r_hit_p0  <= '0;
      r_str_p1  <= '0;
      r_lcnt_p2 <= '0;
      r_tcnt_p2 <= '0;
      r_nlay_p2 <= '0;
      r_cond_p3 <= '0;
    end else begin
      r_hit_p0 <= hit_in & ch_mask;
      for (int c = 0; c < N_CH; c++) begin
        if (r_hit_p0[c])
          r_str_p1[c] <= coincidence_time;
        else if (r_str_p1[c] != 6'd0)
          r_str_p1[c] <= r_str_p1[c] - 6'd1;
      end
      r_lcnt_p2 <= w_lcnt;
      r_tcnt_p2 <= w_tcnt;
      r_nlay_p2 <= w_nlay;
      r_cond_p3 <= w_cond;
    end
  end

  // Trigger pulse timing runs off its own counter so it ignores FSM progress
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_win      <= '0;
      r_bits     <= '0;
      r_ts_lat   <= '0;
      r_trig     <= 1'b0;
      r_trig_rem <= '0;
    end else if (clear) begin
      r_state    <= S_IDLE;
      r_win      <= '0;
      r_bits     <= '0;
      r_ts_lat   <= '0;
      r_trig     <= 1'b0;
      r_trig_rem <= '0;
    end else begin
      if (r_trig_rem != 5'd0)
        r_trig_rem <= r_trig_rem - 5'd1;
      else
        r_trig <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|w_accept) begin
            r_bits     <= w_accept;
            r_ts_lat   <= r_ts;
            r_win      <= w_win_load;
            r_trig     <= 1'b1;
            r_trig_rem <= w_width_load - 5'd1;
            r_state    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          r_bits <= r_bits | w_accept;
          r_win  <= r_win - 8'd1;
          if (r_win == 8'd1)
            r_state <= S_COMMIT;
        end
        S_COMMIT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign w_commit = (r_state == S_COMMIT);
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop    = !w_empty && rec_ready;
  assign w_push   = w_commit && (!w_full || w_pop);

  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= '0;
      r_ts     <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= '0;
      r_ts     <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (w_push)
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      if (w_commit && !w_push && r_ovf != 16'hFFFF)
        r_ovf <= r_ovf + 16'd1;
    end
  end

  // Storage needs no reset: outputs are gated by the empty flag
  always_ff @(posedge clk_adc) begin
    if (w_push && !clear) begin
      r_mem_bits[r_wr_ptr[AW-1:0]] <= r_bits;
      r_mem_ts[r_wr_ptr[AW-1:0]]   <= r_ts_lat;
    end
  end

  assign rec_valid    = !w_empty;
  assign rec_bits     = w_empty ? '0 : r_mem_bits[r_rd_ptr[AW-1:0]];
  assign rec_ts       = w_empty ? '0 : r_mem_ts[r_rd_ptr[AW-1:0]];
  assign trig_out     = r_trig;
  assign overflow_cnt = r_ovf;
  assign timestamp    = r_ts;

endmodule
